keypad_history_display: RTL
===========================

# keypad_history_display

Parametrised keypad-to-display controller for an N-digit multiplexed seven-segment display. It scans a 4×4 matrix keypad, debounces press and release, and shifts each accepted key into an N-digit history register, newest digit in position 0. It time-multiplexes the history onto the shared segment bus. It sits directly below the board top, which supplies the 48 MHz HSOSC clock.

## Interface
- `NUM_DIGITS`, default 2: number of display digits and history depth; legal range 1..8.
- `SCAN_DIV`, default 48000: clk cycles per scan tick (column step or debounce sample).
- `DEBOUNCE_SCANS`, default 4: number of consecutive agreeing ticks needed to accept a press or a release; legal range ≥1.
- `DIGIT_DIV`, default 48000: clk cycles per display digit slot.
- `clk`  in  1: single clock, all state on its rising edge.
- `nreset`  in  1: reset, asynchronous assert, active-low.
- `rows`  in  4: keypad rows, pulled up; 0 = pressed; asynchronous to clk.
- `cols`  out  4: column drive, one-hot active-low.
- `seg`  out  7: segments {g..a}, active-low.
- `dig_en`  out  NUM_DIGITS: digit enables, one-hot, active-high.
- `key_valid`  out  1: one-cycle pulse on each accepted press.
- `key`  out  4: hex code of the last accepted key; holds between presses.

## Operation
- `rows` passes through a 2-flop synchroniser before any use.
- Scan tick: a free-running counter over 0..SCAN_DIV-1; tick asserts when it reaches SCAN_DIV-1.
- Key map, row r / col c, row 0 at top: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = E 0 F D.
- If several rows read low in the driven column, the lowest row index wins.
- Scanner FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
  - SCAN: on each tick, if any synced row is low, latch row/col, clear the debounce count and go to PRESS_DB. Otherwise rotate `cols` to the next column (c3 wraps to c0).
  - PRESS_DB: the column stays fixed. On each tick, if the latched row is still low, increment the count; else return to SCAN without rotating. When the count reaches DEBOUNCE_SCANS, do three things in the same cycle: pulse `key_valid`, update `key`, and shift the history. Then go to HELD.
  - HELD: on a tick with the latched row high, clear the count and go to RELEASE_DB. Other keys pressed in this state are ignored.
  - RELEASE_DB: on each tick, if the latched row is high, increment the count; if it is low, go back to HELD. When the count reaches DEBOUNCE_SCANS, go to SCAN and resume rotation from the same column.
- History shift: digit[i] ← digit[i-1] for i ≥ 1; digit[0] ← new key. The oldest digit is discarded.
- Display: a slot counter steps every DIGIT_DIV cycles and wraps from NUM_DIGITS-1 to 0. `dig_en` bit i and `seg` = decode(digit[i]) come from the same registered slot value, so they change on the same edge.
- Counter widths are $clog2 of their limits, minimum 1 bit. Counters never exceed their limits.

## Timing
- Reset values:
  - `cols`=4'b1110
  - `dig_en`=one-hot bit 0
  - `key_valid`=0, `key`=0
  - history all 0
  - FSM=SCAN; all counters 0
  - `seg`=decode(0), or blank per the Configuration section.
- Press to `key_valid`: synchroniser (2 clk) + up to SCAN_DIV×4 for the detect tick + DEBOUNCE_SCANS ticks.
- `key_valid` is high for exactly 1 clk. `key` and the history update in the same cycle, and the new `seg` appears no later than the next slot change.
- Reset asserted mid-debounce or mid-hold: all state returns immediately to reset values and no `key_valid` is emitted.
- After reset deassertion, a key that is still held must be freshly debounced before it is accepted.

## Configuration
- `KEYPAD_BLANK_LEADING_EN`
  - Defined: a fill counter (0..NUM_DIGITS, saturating) increments on each accepted key. A digit i with i ≥ fill drives `seg`=7'h7F (all off), so after reset the display is fully blank.
  - Undefined: there is no fill counter and unfilled digits show 0.

## Structure
- Package `keypad_pkg` holds:
  - the scanner state enum
  - the 4×4 key map constant
  - the hex-to-seven-segment pattern constant
  - the blank pattern.
- Sub-module `keypad_scanner` contains the synchroniser, scan tick, FSM and key map. Its outputs are `cols`, `key_valid` and `key`.
- The top level holds the history, the optional fill counter and the display multiplexer.

## Test plan
Bench parameters: SCAN_DIV=4, DIGIT_DIV=3, DEBOUNCE_SCANS=3, NUM_DIGITS=2.
- Reset, no stimulus: `cols` rotates 1110→1101→1011→0111→1110 every 4 clk. `key_valid` stays 0. `dig_en` alternates 01/10 every 3 clk.
- Hold row1 low while c1 is driven: exactly one `key_valid` pulse and `key`=5. Then digit[0]=5 shown when `dig_en`=01, and digit[1] shown per the macro (0 undefined, blank defined).
- Row0 low for 2 ticks only: no `key_valid`; scan resumes.
- Press 1 (row0 while c0 driven), then 2 (row0 while c1 driven), then 3 (row0 while c2 driven), each followed by a full release: `key_valid` ×3, final history digit[1]=2, digit[0]=3, and the 1 is discarded.
- Hold 1, then also press 9 without releasing: no second `key_valid` until 1 is released and 9 is re-detected.
- Assert `nreset` while in PRESS_DB: no pulse, outputs at reset values, and history unchanged from 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the keypad history display:
//   - scanner state encoding
//   - 4x4 key map (row-major, index = {row, col}, row 0 at top)
//   - active-low seven-segment patterns {g..a} for hex digits 0..F
//   - blank pattern (all segments off)
//   - clog2 helper that never returns less than 1 bit
// ----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } scan_state_e;

    // Element 0 is row 0 / col 0. Listed from index 15 down to index 0.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,   // row 3: c3 c2 c1 c0
        4'hC, 4'h9, 4'h8, 4'h7,   // row 2
        4'hB, 4'h6, 4'h5, 4'h4,   // row 1
        4'hA, 4'h3, 4'h2, 4'h1    // row 0
    };

    // Active-low {g,f,e,d,c,b,a}; listed from F down to 0.
    localparam logic [15:0][6:0] SEG_MAP = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/keypad_history_display_scanner.sv
// ----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, debounces press and release and
// reports each accepted key.
//   Scanner states:
//     state         | meaning
//     ST_SCAN       | rotating the driven column, looking for any low row
//     ST_PRESS_DB   | column frozen, counting agreeing "pressed" ticks
//     ST_HELD       | key accepted, waiting for the latched row to go high
//     ST_RELEASE_DB | counting agreeing "released" ticks before rescanning
// Ports:
//   clk, nreset      clock, async active-low reset
//   rows[3:0]        keypad rows (async, 0 = pressed)
//   cols[3:0]        one-hot active-low column drive
//   key_valid        one-cycle pulse per accepted press
//   key[3:0]         hex code of last accepted key
// ----------------------------------------------------------------------------
import keypad_pkg::*;

module keypad_scanner #(
    parameter int SCAN_DIV       = 48000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key
);

    localparam int SCAN_W = clog2_min1(SCAN_DIV);
    localparam int DB_W   = clog2_min1(DEBOUNCE_SCANS + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    // The detect tick itself is not counted, so the press is accepted on the
    // tick that would bring the count to DEBOUNCE_SCANS.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_SCANS - 1);

    logic [3:0]        r_rows_meta;
    logic [3:0]        r_rows_sync;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [1:0]        r_col;
    logic [1:0]        r_row;
    logic [DB_W-1:0]   r_db_cnt;
    scan_state_e       r_state;
    logic              r_key_valid;
    logic [3:0]        r_key;

    logic              w_tick;
    logic              w_any_low;
    logic              w_latched_low;
    logic [1:0]        w_row_first;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rows_meta <= 4'hF;
            r_rows_sync <= 4'hF;
        end else begin
            r_rows_meta <= rows;
            r_rows_sync <= r_rows_meta;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            r_scan_cnt <= '0;
        else if (r_scan_cnt == SCAN_LAST)
            r_scan_cnt <= '0;
        else
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end

    assign w_tick        = (r_scan_cnt == SCAN_LAST);
    assign w_any_low     = ~&r_rows_sync;
    assign w_latched_low = ~r_rows_sync[r_row];

    // Lowest-index low row wins: scan downwards so row 0 overrides last.
    always_comb begin
        w_row_first = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_rows_sync[i])
                w_row_first = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= ST_SCAN;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_db_cnt    <= '0;
            r_key_valid <= 1'b0;
            r_key       <= 4'h0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_any_low) begin
                            r_row    <= w_row_first;
                            r_db_cnt <= '0;
                            r_state  <= ST_PRESS_DB;
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end
                    ST_PRESS_DB: begin
                        if (w_latched_low) begin
                            if (r_db_cnt == DB_LAST) begin
                                r_key_valid <= 1'b1;
                                r_key       <= KEY_MAP[{r_row, r_col}];
                                r_db_cnt    <= '0;
                                r_state     <= ST_HELD;
                            end else begin
                                r_db_cnt <= r_db_cnt + DB_W'(1);
                            end
                        end else begin
                            r_db_cnt <= '0;
                            r_state  <= ST_SCAN;
                        end
                    end
                    ST_HELD: begin
                        if (!w_latched_low) begin
                            r_db_cnt <= '0;
                            r_state  <= ST_RELEASE_DB;
                        end
                    end
                    ST_RELEASE_DB: begin
                        if (!w_latched_low) begin
                            if (r_db_cnt == DB_LAST) begin
                                r_db_cnt <= '0;
                                r_state  <= ST_SCAN;
                            end else begin
                                r_db_cnt <= r_db_cnt + DB_W'(1);
                            end
                        end else begin
                            r_db_cnt <= '0;
                            r_state  <= ST_HELD;
                        end
                    end
                    default: r_state <= ST_SCAN;
                endcase
            end
        end
    end

    assign cols      = ~(4'b0001 << r_col);
    assign key_valid = r_key_valid;
    assign key       = r_key;

endmodule

// File: rtl/keypad_history_display.sv
// ----------------------------------------------------------------------------
// keypad_history_display
// Keypad-to-display controller: scans/debounces a 4x4 keypad, keeps an
// N-digit history of accepted keys (newest in digit 0) and multiplexes the
// history onto a shared active-low seven-segment bus.
// Ports:
//   clk, nreset          48 MHz clock, async active-low reset
//   rows[3:0]            keypad rows (async, 0 = pressed)
//   cols[3:0]            one-hot active-low column drive
//   seg[6:0]             segments {g..a}, active-low
//   dig_en[NUM_DIGITS-1:0] one-hot active-high digit enable
//   key_valid            one-cycle pulse per accepted press
//   key[3:0]             last accepted key
// Build option:
//   KEYPAD_BLANK_LEADING_EN  blank digits that have not yet received a key
// ----------------------------------------------------------------------------
import keypad_pkg::*;

module keypad_history_display #(
    parameter int NUM_DIGITS     = 2,
    parameter int SCAN_DIV       = 48000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int DIGIT_DIV      = 48000
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [3:0]            rows,
    output logic [3:0]            cols,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  key_valid,
    output logic [3:0]            key
);

    localparam int DIG_W  = clog2_min1(DIGIT_DIV);
    localparam int SLOT_W = clog2_min1(NUM_DIGITS);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGIT_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

    logic                       w_key_valid;
    logic [3:0]                 w_key;
    logic [NUM_DIGITS-1:0][3:0] r_hist;
    logic [DIG_W-1:0]           r_dig_cnt;
    logic [SLOT_W-1:0]          r_slot;
    logic [6:0]                 w_seg_digit;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk       (clk),
        .nreset    (nreset),
        .rows      (rows),
        .cols      (cols),
        .key_valid (w_key_valid),
        .key       (w_key)
    );

    // key is registered together with key_valid, so the history captures
    // the new code while the pulse is high.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_hist <= '0;
        end else if (w_key_valid) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--)
                r_hist[i] <= r_hist[i-1];
            r_hist[0] <= w_key;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_dig_cnt <= '0;
            r_slot    <= '0;
        end else if (r_dig_cnt == DIG_LAST) begin
            r_dig_cnt <= '0;
            r_slot    <= (r_slot == SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
        end else begin
            r_dig_cnt <= r_dig_cnt + DIG_W'(1);
        end
    end

    assign w_seg_digit = SEG_MAP[r_hist[r_slot]];

`ifdef KEYPAD_BLANK_LEADING_EN
    localparam int FILL_W = clog2_min1(NUM_DIGITS + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_DIGITS);

    logic [FILL_W-1:0] r_fill;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            r_fill <= '0;
        else if (w_key_valid && (r_fill != FILL_MAX))
            r_fill <= r_fill + FILL_W'(1);
    end

    assign seg = (32'(r_slot) >= 32'(r_fill)) ? SEG_BLANK : w_seg_digit;
`else
    assign seg = w_seg_digit;
`endif

    assign dig_en    = NUM_DIGITS'(1) << r_slot;
    assign key_valid = w_key_valid;
    assign key       = w_key;

endmodule
